writeback_queue: RTL

//  Write-side producer for the 32x32 register file (3-port: A1/A2 read, A3/WD3/WE3 write).

---
 rtl/writeback_queue.sv | 78 +++++++
 1 files changed

// File: rtl/writeback_queue.sv
// writeback_queue: in-order writeback FIFO draining into a register file write port with hazard query.
// Optional WB_BYPASS_EN builds the youngest-match data bypass on q1_data/q2_data.
module writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_addr,
  input  logic [DW-1:0]              in_data,
  input  logic                       wb_hold,
  output logic                       WE3,
  output logic [AW-1:0]              A3,
  output logic [DW-1:0]              WD3,
  input  logic [AW-1:0]              q1_addr,
  input  logic [AW-1:0]              q2_addr,
  output logic                       q1_hit,
  output logic                       q2_hit,
  output logic [DW-1:0]              q1_data,
  output logic [DW-1:0]              q2_data,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid;
  logic push, keep, pop, busy;
  assign busy = count != '0;
  assign in_ready = !reset && count != CW'(DEPTH);
  assign WE3 = !reset && busy && !wb_hold;
  assign push = in_valid && in_ready;
  assign keep = push && in_addr != '0;
  assign pop = WE3;
  assign A3 = busy ? addr_q[rd_ptr] : '0;
  assign WD3 = busy ? data_q[rd_ptr] : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      valid <= '0;
      count <= '0;
    end else begin
      if (keep) begin
        addr_q[wr_ptr] <= in_addr;
        data_q[wr_ptr] <= in_data;
        valid[wr_ptr] <= 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(keep) - CW'(pop);
    end
  end
  // scanning oldest to youngest lets the youngest match win
  function automatic logic [DW:0] lookup(input logic [AW-1:0] a);
    logic [DW:0] r;
    logic [PW-1:0] i;
    r = '0;
    for (int k = 0; k < DEPTH; k++) begin
      i = rd_ptr + PW'(k);
`ifdef WB_BYPASS_EN
      if (a != '0 && valid[i] && addr_q[i] == a) r = {1'b1, data_q[i]};
`else
      if (a != '0 && valid[i] && addr_q[i] == a) r[DW] = 1'b1;
`endif
    end
    return r;
  endfunction
  assign {q1_hit, q1_data} = lookup(q1_addr);
  assign {q2_hit, q2_data} = lookup(q2_addr);
endmodule
